fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: the producing end of the opcode stream consumed by the decode control unit. Owns the PC, issues addresses to a synchronous-read instruction memory, and assembles one- and two-word instructions (opcode word plus immediate word). Delivers complete instructions into the IF/ID pipeline register, handling decode stalls and EX-stage redirects.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset.
- `ADDR_W`, default 20: PC / instruction-memory address width, word-addressed.
- `INSTR_W`, default 16: instruction word width; opcode = `word[INSTR_W-1 -: 6]`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_addr` output ADDR_W: read address; always equals the PC register.
- `imem_rdata` input INSTR_W: memory data for the address presented the previous cycle.
- `stall_i` input 1: decode cannot accept; hold IF/ID and PC.
- `redirect_i` input 1: taken branch/jump from EX; squash fetched state.
- `redirect_pc_i` input ADDR_W: new PC when `redirect_i` is high.
- `ifid_valid` output 1: IF/ID holds a complete instruction.
- `ifid_instr` output INSTR_W: opcode word.
- `ifid_imm` output INSTR_W: immediate word (two-word instructions), else 0.
- `ifid_pc` output ADDR_W: address of the opcode word.

## Operation
- Registers: `pc`, `req_valid`/`req_pc` (one in-flight read), one-entry hold buffer (`hold_valid`, `hold_word`, `hold_pc`), FSM, first-word latch, IF/ID outputs.
- Reset: `pc`=RESET_PC. `req_valid`, `hold_valid`, `ifid_valid`=0. `ifid_instr`/`ifid_imm`/`ifid_pc`=0. FSM=`FIRST`.
- Priority: `rst` > `redirect_i` > `stall_i`.
- Normal: each non-stalled cycle `pc`<=`pc`+1 (wraps mod 2^ADDR_W), `req_valid`<=1, `req_pc`<=`pc`.
- Word source: the hold buffer if `hold_valid`, else `imem_rdata` when `req_valid`.
- FSM `FIRST`: word opcode in two-word set (`OPC_LDM`): latch word and pc, go to `SECOND`, no IF/ID write. Otherwise write IF/ID with `ifid_imm`=0 and assert `ifid_valid`.
- FSM `SECOND`: write IF/ID with `ifid_instr`=latched word, `ifid_imm`=current word, `ifid_pc`=latched pc; go to `FIRST`.
- No word available in a non-stalled cycle: `ifid_valid`<=0 (bubble).
- Stall: `pc`, IF/ID and FSM hold. A word returning during the stall goes to the hold buffer. The next memory issue waits until the buffer is consumed, so at most one word is buffered.
- Redirect: `pc`<=`redirect_pc_i`. `req_valid`, `hold_valid`, `ifid_valid`<=0. FSM<=`FIRST` and the first-word latch is discarded. Applies even while `stall_i` is high.

## Timing
- Cycle 0 (first after `rst` falls): `imem_addr`=RESET_PC. Cycle 1: data returns. Cycle 2: `ifid_valid`=1 for a single-word instruction.
- Steady state: one word per cycle. Single-word instructions 1/cycle. A two-word instruction yields one valid slot per 2 cycles and a bubble between.
- Redirect in cycle N: `imem_addr`=target in N+1, `ifid_valid`=0 in N+1 and N+2, first target instruction valid in N+3.
- Stall release in cycle N: the buffered word is consumed in N. PC issue resumes in N; no word is lost or duplicated.
- Reset mid-operation: all state returns to reset values the next edge, including mid-`SECOND`.

## Configuration
- `FETCH_TWO_WORD_EN` defined: FSM and two-word assembly as above.
- Not defined: no FSM. Every word is a single-word instruction, `ifid_imm` is tied to 0, and decode must flush the immediate word itself.

## Structure
- `fetch_pkg` holds:
  - opcode constants (`OPC_LDM`, `OPC_ADD`, ...);
  - the `is_two_word(opcode)` function;
  - the FSM state typedef (`FIRST`, `SECOND`).
- One sub-module, `fetch_hold_buf`: the one-entry word/pc hold buffer with load/consume/clear.

## Test plan
- Reset, memory holds 0x2C00 (ADD) at 0..3 -> `ifid_valid` rises cycle 2, `ifid_pc` 0,1,2,3 on consecutive cycles.
- 0x0400 (LDM) at addr 0, 0xBEEF at addr 1 -> one valid slot: `ifid_instr`=0x0400, `ifid_imm`=0xBEEF, `ifid_pc`=0.
- `stall_i` high 3 cycles mid-stream -> outputs frozen; after release `ifid_pc` sequence continues with no gap or repeat.
- `redirect_i` with `redirect_pc_i`=0x100 while in `SECOND` -> latch dropped, two bubbles, next valid `ifid_pc`=0x100.
- `rst` asserted during a stall with `hold_valid`=1 -> next cycle `ifid_valid`=0, `imem_addr`=RESET_PC, buffer empty.
- `pc` at 2^ADDR_W-1 -> next `imem_addr`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode constants, two-word decode helper and FSM states
// shared by the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned OPC_W = 6;

   typedef logic [OPC_W-1:0] opc_t;

   localparam opc_t OPC_NOP = 6'h00;
   localparam opc_t OPC_LDM = 6'h01;
   localparam opc_t OPC_LD  = 6'h02;
   localparam opc_t OPC_ST  = 6'h03;
   localparam opc_t OPC_MOV = 6'h04;
   localparam opc_t OPC_ADD = 6'h0B;
   localparam opc_t OPC_SUB = 6'h0C;
   localparam opc_t OPC_AND = 6'h0D;
   localparam opc_t OPC_OR  = 6'h0E;
   localparam opc_t OPC_XOR = 6'h0F;
   localparam opc_t OPC_BEQ = 6'h20;
   localparam opc_t OPC_BNE = 6'h21;
   localparam opc_t OPC_JMP = 6'h22;

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } fetch_state_e;

   // Only LDM carries a trailing immediate word.
   function automatic logic is_two_word(input opc_t opc);
      return opc == OPC_LDM;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory bus and IF/ID register outputs of the
// fetch stage; master is the fetch unit, slave the memory/decode side.
interface fetch_if #(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned INSTR_W = 16
) ();

   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [INSTR_W-1:0] ifid_imm;
   logic [ADDR_W-1:0]  ifid_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output ifid_valid,
      output ifid_instr,
      output ifid_imm,
      output ifid_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  ifid_valid,
      input  ifid_instr,
      input  ifid_imm,
      input  ifid_pc
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry word/pc buffer catching a memory word that
// returns while decode is stalled. clear > load > consume.
module fetch_hold_buf
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               load_i,
   input  logic               consume_i,
   input  logic [INSTR_W-1:0] word_i,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               valid_o,
   output logic [INSTR_W-1:0] word_o,
   output logic [ADDR_W-1:0]  pc_o
);

   logic               valid_q;
   logic               valid_d;
   logic [INSTR_W-1:0] word_q;
   logic [INSTR_W-1:0] word_d;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  pc_d;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      pc_d    = pc_q;
      unique case (1'b1)
         clear_i: begin
            valid_d = 1'b0;
         end
         load_i & ~clear_i: begin
            valid_d = 1'b1;
            word_d  = word_i;
            pc_d    = pc_i;
         end
         consume_i & ~clear_i & ~load_i: begin
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem issue and IF/ID register of the fetch stage.
// Define FETCH_TWO_WORD_EN to assemble LDM opcode+immediate pairs.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 20,
   parameter int unsigned       INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   fetch_if.master           bus
);

   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  pc_d;
   logic               req_valid_q;
   logic               req_valid_d;
   logic [ADDR_W-1:0]  req_pc_q;
   logic [ADDR_W-1:0]  req_pc_d;

   logic               vld_q;
   logic               vld_d;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] instr_d;
   logic [ADDR_W-1:0]  ifpc_q;
   logic [ADDR_W-1:0]  ifpc_d;

   logic               hb_valid;
   logic [INSTR_W-1:0] hb_word;
   logic [ADDR_W-1:0]  hb_pc;
   logic               hb_clear;
   logic               hb_load;
   logic               hb_consume;

   logic               word_vld;
   logic [INSTR_W-1:0] word;
   logic [ADDR_W-1:0]  word_pc;

`ifdef FETCH_TWO_WORD_EN
   fetch_state_e       state_q;
   fetch_state_e       state_d;
   logic [INSTR_W-1:0] imm_q;
   logic [INSTR_W-1:0] imm_d;
   logic [INSTR_W-1:0] lat_word_q;
   logic [INSTR_W-1:0] lat_word_d;
   logic [ADDR_W-1:0]  lat_pc_q;
   logic [ADDR_W-1:0]  lat_pc_d;
`endif

   fetch_hold_buf #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (hb_clear),
      .load_i    (hb_load),
      .consume_i (hb_consume),
      .word_i    (bus.imem_rdata),
      .pc_i      (req_pc_q),
      .valid_o   (hb_valid),
      .word_o    (hb_word),
      .pc_o      (hb_pc)
   );

   // A buffered word is always older than anything in flight.
   assign word_vld = hb_valid | req_valid_q;
   assign word     = hb_valid ? hb_word : bus.imem_rdata;
   assign word_pc  = hb_valid ? hb_pc : req_pc_q;

   always_comb begin
      pc_d        = pc_q;
      req_valid_d = req_valid_q;
      req_pc_d    = req_pc_q;
      hb_clear    = 1'b0;
      hb_load     = 1'b0;
      hb_consume  = 1'b0;
      vld_d       = vld_q;
      instr_d     = instr_q;
      ifpc_d      = ifpc_q;
`ifdef FETCH_TWO_WORD_EN
      state_d     = state_q;
      imm_d       = imm_q;
      lat_word_d  = lat_word_q;
      lat_pc_d    = lat_pc_q;
`endif
      unique case (1'b1)
         redirect_i: begin
            pc_d        = redirect_pc_i;
            req_valid_d = 1'b0;
            hb_clear    = 1'b1;
            vld_d       = 1'b0;
`ifdef FETCH_TWO_WORD_EN
            state_d     = FIRST;
            lat_word_d  = '0;
            lat_pc_d    = '0;
`endif
         end
         stall_i & ~redirect_i: begin
            // The read completes now; park it and stop issuing.
            req_valid_d = 1'b0;
            hb_load     = req_valid_q & ~hb_valid;
         end
         default: begin
            pc_d        = pc_q + ADDR_W'(1);
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            hb_consume  = hb_valid;
            vld_d       = 1'b0;
            if (word_vld) begin
`ifdef FETCH_TWO_WORD_EN
               unique case (state_q)
                  FIRST: begin
                     if (is_two_word(word[INSTR_W-1 -: OPC_W])) begin
                        lat_word_d = word;
                        lat_pc_d   = word_pc;
                        state_d    = SECOND;
                     end else begin
                        vld_d   = 1'b1;
                        instr_d = word;
                        imm_d   = '0;
                        ifpc_d  = word_pc;
                     end
                  end
                  SECOND: begin
                     vld_d   = 1'b1;
                     instr_d = lat_word_q;
                     imm_d   = word;
                     ifpc_d  = lat_pc_q;
                     state_d = FIRST;
                  end
               endcase
`else
               vld_d   = 1'b1;
               instr_d = word;
               ifpc_d  = word_pc;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
         vld_q       <= 1'b0;
         instr_q     <= '0;
         ifpc_q      <= '0;
`ifdef FETCH_TWO_WORD_EN
         state_q     <= FIRST;
         imm_q       <= '0;
         lat_word_q  <= '0;
         lat_pc_q    <= '0;
`endif
      end else begin
         pc_q        <= pc_d;
         req_valid_q <= req_valid_d;
         req_pc_q    <= req_pc_d;
         vld_q       <= vld_d;
         instr_q     <= instr_d;
         ifpc_q      <= ifpc_d;
`ifdef FETCH_TWO_WORD_EN
         state_q     <= state_d;
         imm_q       <= imm_d;
         lat_word_q  <= lat_word_d;
         lat_pc_q    <= lat_pc_d;
`endif
      end
   end

   assign bus.imem_addr  = pc_q;
   assign bus.ifid_valid = vld_q;
   assign bus.ifid_instr = instr_q;
   assign bus.ifid_pc    = ifpc_q;
`ifdef FETCH_TWO_WORD_EN
   assign bus.ifid_imm   = imm_q;
`else
   assign bus.ifid_imm   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random memory, stalls and
// redirects scored against an instruction-walk model of the program.
module tb_fetch_unit;

   localparam int unsigned    AW    = 20;
   localparam int unsigned    IW    = 16;
   localparam logic [AW-1:0]  RPC   = '0;
   localparam logic [5:0]     LDM   = 6'h01;
   localparam logic [IW-1:0]  ADD_W = 16'h2C00;

   typedef struct packed {
      logic          vld;
      logic [IW-1:0] instr;
      logic [IW-1:0] imm;
      logic [AW-1:0] pc;
   } obs_t;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          stall = 1'b0;
   logic          redir = 1'b0;
   logic [AW-1:0] rpc   = '0;
   logic [IW-1:0] mem [0:1023];
   int            checks = 0;
   int            fails  = 0;

   fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   fetch_unit #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .RESET_PC (RPC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall),
      .redirect_i    (redir),
      .redirect_pc_i (rpc),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[9:0]];

   function automatic obs_t sample();
      obs_t o;
      o.vld   = bus.ifid_valid;
      o.instr = bus.ifid_instr;
      o.imm   = bus.ifid_imm;
      o.pc    = bus.ifid_pc;
      return o;
   endfunction

   // Instruction at address a as the program defines it; nxt = following one.
   function automatic obs_t model_at(input logic [AW-1:0] a,
                                     output logic [AW-1:0] nxt);
      obs_t          e;
      logic [AW-1:0] a1;
      a1      = a + AW'(1);
      e.vld   = 1'b1;
      e.pc    = a;
      e.instr = mem[a[9:0]];
      e.imm   = '0;
      nxt     = a1;
`ifdef FETCH_TWO_WORD_EN
      if (e.instr[IW-1 -: 6] == LDM) begin
         e.imm = mem[a1[9:0]];
         nxt   = a1 + AW'(1);
      end
`endif
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst   = 1'b1;
      stall = 1'b0;
      redir = 1'b0;
      step();
      step();
   endtask

   task automatic fill_unique();
      for (int i = 0; i < 1024; i++) mem[i] = ADD_W | IW'(i);
   endtask

   task automatic test_reset();
      obs_t o;
      fill_unique();
      apply_reset();
      o = sample();
      checks++;
      if (o.vld !== 1'b0) begin
         fails++; $display("FAIL reset_valid got=%0h exp=0", o.vld);
      end
      checks++;
      if (o.instr !== '0) begin
         fails++; $display("FAIL reset_instr got=%0h exp=0", o.instr);
      end
      checks++;
      if (o.imm !== '0) begin
         fails++; $display("FAIL reset_imm got=%0h exp=0", o.imm);
      end
      checks++;
      if (o.pc !== '0) begin
         fails++; $display("FAIL reset_pc got=%0h exp=0", o.pc);
      end
      checks++;
      if (bus.imem_addr !== RPC) begin
         fails++; $display("FAIL reset_addr got=%0h exp=%0h", bus.imem_addr, RPC);
      end
   endtask

   task automatic test_single_word();
      obs_t o;
      for (int i = 0; i < 1024; i++) mem[i] = ADD_W;
      apply_reset();
      rst = 1'b0;
      o = sample();
      checks++;
      if (bus.imem_addr !== RPC || o.vld !== 1'b0) begin
         fails++;
         $display("FAIL sw_cycle0 addr=%0h vld=%0h exp addr=%0h vld=0",
                  bus.imem_addr, o.vld, RPC);
      end
      step();
      o = sample();
      checks++;
      if (o.vld !== 1'b0) begin
         fails++; $display("FAIL sw_cycle1 vld got=%0h exp=0", o.vld);
      end
      for (int c = 2; c <= 5; c++) begin
         step();
         o = sample();
         checks++;
         if (o.vld !== 1'b1 || o.pc !== RPC + AW'(c - 2) ||
             o.instr !== ADD_W || o.imm !== '0) begin
            fails++;
            $display("FAIL sw_stream c=%0d got=%h exp pc=%0h", c, o,
                     RPC + AW'(c - 2));
         end
      end
   endtask

   task automatic test_two_word();
      obs_t          o;
      obs_t          e0;
      obs_t          e1;
      logic [AW-1:0] n1;
      logic [AW-1:0] n2;
      int            t0;
      int            t1;
      fill_unique();
      mem[0] = 16'h0400;
      mem[1] = 16'hBEEF;
      e0 = model_at(RPC, n1);
      e1 = model_at(n1, n2);
      t0 = 1 + ((n1 - RPC == AW'(2)) ? 2 : 1);
      t1 = t0 + ((n2 - n1 == AW'(2)) ? 2 : 1);
      apply_reset();
      rst = 1'b0;
      for (int c = 1; c <= t1; c++) begin
         step();
         o = sample();
         checks++;
         if (c == t0) begin
            if (o !== e0) begin
               fails++; $display("FAIL tw_first c=%0d got=%h exp=%h", c, o, e0);
            end
         end else if (c == t1) begin
            if (o !== e1) begin
               fails++; $display("FAIL tw_next c=%0d got=%h exp=%h", c, o, e1);
            end
         end else if (o.vld !== 1'b0) begin
            fails++; $display("FAIL tw_bubble c=%0d vld got=%0h exp=0", c, o.vld);
         end
      end
   endtask

   task automatic test_stall();
      obs_t          o;
      obs_t          snap;
      obs_t          e;
      logic [AW-1:0] mpc;
      logic [AW-1:0] n;
      fill_unique();
      apply_reset();
      rst = 1'b0;
      repeat (4) step();
      snap  = sample();
      stall = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         if (k == 3) stall = 1'b0;
         o = sample();
         checks++;
         if (o !== snap) begin
            fails++; $display("FAIL stall_frozen k=%0d got=%h exp=%h", k, o, snap);
         end
      end
      mpc = snap.pc + AW'(1);
      for (int k = 1; k <= 4; k++) begin
         step();
         o = sample();
         e = model_at(mpc, n);
         mpc = n;
         checks++;
         if (o !== e) begin
            fails++; $display("FAIL stall_resume k=%0d got=%h exp=%h", k, o, e);
         end
      end
   endtask

   task automatic test_redirect_second();
      obs_t          o;
      obs_t          e;
      logic [AW-1:0] n;
      fill_unique();
      mem[0] = 16'h0400;
      mem[1] = 16'hBEEF;
      apply_reset();
      rst = 1'b0;
      step();
      step();
      redir = 1'b1;
      rpc   = AW'(20'h00100);
      step();
      redir = 1'b0;
      o = sample();
      checks++;
      if (bus.imem_addr !== AW'(20'h00100) || o.vld !== 1'b0) begin
         fails++;
         $display("FAIL redir_n1 addr=%0h vld=%0h exp addr=100 vld=0",
                  bus.imem_addr, o.vld);
      end
      step();
      o = sample();
      checks++;
      if (o.vld !== 1'b0) begin
         fails++; $display("FAIL redir_n2 vld got=%0h exp=0", o.vld);
      end
      step();
      o = sample();
      e = model_at(AW'(20'h00100), n);
      checks++;
      if (o !== e) begin
         fails++; $display("FAIL redir_n3 got=%h exp=%h", o, e);
      end
      step();
      o = sample();
      e = model_at(n, n);
      checks++;
      if (o !== e) begin
         fails++; $display("FAIL redir_n4 got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_reset_in_stall();
      obs_t o;
      fill_unique();
      apply_reset();
      rst = 1'b0;
      repeat (4) step();
      stall = 1'b1;
      step();
      rst = 1'b1;
      step();
      o = sample();
      checks++;
      if (o.vld !== 1'b0 || o.pc !== '0 || bus.imem_addr !== RPC) begin
         fails++;
         $display("FAIL rst_stall got=%h addr=%0h exp vld=0 pc=0 addr=%0h",
                  o, bus.imem_addr, RPC);
      end
      rst   = 1'b0;
      stall = 1'b0;
      step();
      o = sample();
      checks++;
      if (o.vld !== 1'b0) begin
         fails++; $display("FAIL rst_stall_c1 vld got=%0h exp=0", o.vld);
      end
      step();
      o = sample();
      checks++;
      if (o.vld !== 1'b1 || o.pc !== RPC || o.instr !== mem[RPC[9:0]]) begin
         fails++; $display("FAIL rst_stall_c2 got=%h exp pc=%0h", o, RPC);
      end
   endtask

   task automatic test_wrap();
      obs_t          o;
      obs_t          e;
      logic [AW-1:0] top;
      logic [AW-1:0] n;
      fill_unique();
      top = '1;
      apply_reset();
      rst = 1'b0;
      step();
      redir = 1'b1;
      rpc   = top;
      step();
      redir = 1'b0;
      checks++;
      if (bus.imem_addr !== top) begin
         fails++; $display("FAIL wrap_top addr got=%0h exp=%0h", bus.imem_addr, top);
      end
      step();
      checks++;
      if (bus.imem_addr !== '0) begin
         fails++; $display("FAIL wrap_zero addr got=%0h exp=0", bus.imem_addr);
      end
      step();
      o = sample();
      e = model_at(top, n);
      checks++;
      if (o !== e) begin
         fails++; $display("FAIL wrap_instr_top got=%h exp=%h", o, e);
      end
      step();
      o = sample();
      e = model_at(n, n);
      checks++;
      if (o !== e) begin
         fails++; $display("FAIL wrap_instr_zero got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_random();
      obs_t          cur;
      obs_t          prev;
      obs_t          e;
      logic [AW-1:0] mpc;
      logic [AW-1:0] n;
      logic [IW-1:0] w;
      logic          pstall;
      int            since;
      int            delivered;
      for (int i = 0; i < 1024; i++) begin
         w = IW'($urandom);
         if ($urandom_range(0, 3) == 0) w[IW-1 -: 6] = LDM;
         else if (w[IW-1 -: 6] == LDM) w[IW-1 -: 6] = 6'h0B;
         mem[i] = w;
      end
      apply_reset();
      rst       = 1'b0;
      mpc       = RPC;
      since     = 99;
      pstall    = 1'b0;
      delivered = 0;
      prev      = sample();
      for (int c = 0; c < 3000; c++) begin
         cur = sample();
         if (since <= 2) begin
            checks++;
            if (cur.vld !== 1'b0) begin
               fails++; $display("FAIL rnd_redir_bubble c=%0d vld got=%0h exp=0", c, cur.vld);
            end
         end else if (pstall) begin
            checks++;
            if (cur !== prev) begin
               fails++; $display("FAIL rnd_stall_hold c=%0d got=%h exp=%h", c, cur, prev);
            end
         end else if (cur.vld === 1'b1) begin
            e = model_at(mpc, n);
            mpc = n;
            delivered++;
            checks++;
            if (cur !== e) begin
               fails++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, cur, e);
            end
         end
         redir = ($urandom_range(0, 39) == 0);
         stall = ($urandom_range(0, 3) == 0);
         if (redir) begin
            rpc   = AW'($urandom);
            mpc   = rpc;
            since = 0;
         end
         pstall = stall & ~redir;
         prev   = cur;
         step();
         if (since < 99) since++;
      end
      redir = 1'b0;
      stall = 1'b0;
      checks++;
      if (delivered < 500) begin
         fails++; $display("FAIL rnd_progress delivered=%0d required>=500", delivered);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_two_word();
      test_stall();
      test_redirect_second();
      test_reset_in_stall();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
